ticket_arbiter: RTL and testbench
=================================

Name: ticket_arbiter

Overview:
Round-robin arbiter that shares a single free-running 8-bit counter among NUM_REQ requesters. Each accepted request receives a one-cycle grant carrying the current counter value as a ticket, and the counter then advances. The block sits beside the counter-based datapath modules in the same clock domain and replaces per-requester counters with one sequenced, shared resource.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 8, counter/ticket width in bits
ID_W, $clog2(NUM_REQ), width of the granted-requester index (derived; not overridden)

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
en  input  1  arbitration enable; when low, no new grants are issued
clr  input  1  synchronous counter clear request
req  input  NUM_REQ  per-requester request level, held until granted
gnt  output  NUM_REQ  one-hot grant pulse, registered
gnt_valid  output  1  high when any gnt bit is high
gnt_id  output  ID_W  index of the granted requester (valid with gnt_valid)
gnt_ticket  output  WIDTH  counter value assigned to this grant
wrap  output  1  one-cycle pulse when the counter rolls over from 2^WIDTH-1 to 0
count  output  WIDTH  current counter value (next ticket to be issued)

Behaviour:
- Reset (rst high at posedge): gnt=0, gnt_valid=0, gnt_id=0, gnt_ticket=0, wrap=0, count=0, rr_ptr=0, FSM=IDLE. rst overrides clr and en.
- FSM states:
  - IDLE: no grant is issued this cycle.
  - GRANT: the gnt registers are high for exactly one cycle.
  - CLEAR: a one-cycle state that zeroes the counter.
- Transitions, evaluated each posedge:
  - clr=1 -> CLEAR, from any state.
  - Otherwise, en=1 and eligible request present -> GRANT.
  - Otherwise -> IDLE.
  - CLEAR always exits to IDLE or GRANT using the same rule on the next edge.
- Eligible request: req[i]=1, excluding the requester whose gnt is high in the current cycle. This masks the stale req the requester has not yet dropped.
- Arbitration: round-robin starting at rr_ptr.
  - The first eligible index at or after rr_ptr (mod NUM_REQ) wins.
  - On a grant to index k, rr_ptr <= (k+1) mod NUM_REQ.
- Latency: req sampled at edge t produces gnt, gnt_id and gnt_ticket visible in the cycle after edge t (registered, one cycle).
- Ticket: gnt_ticket = count value before the increment; count <= count+1 at the same edge.
- Wrap:
  - count wraps modulo 2^WIDTH.
  - wrap pulses in the same cycle as the grant whose ticket is 2^WIDTH-1, and count reads 0 in that cycle.
- clr behaviour:
  - count <= 0, and no grant is issued at that edge.
  - rr_ptr is unchanged.
  - A grant already visible in the current cycle completes normally; pending requests are served after CLEAR.
  - clr and a would-be grant in the same cycle: clr wins; the request stays pending.
- en low: pending requests wait; count and rr_ptr hold; clr still acts.
- A requester must hold req until it sees its gnt. Dropping req early withdraws the request with no side effects.
- At most one grant per cycle. Back-to-back grants to different requesters on consecutive cycles are allowed. Sustained throughput is one ticket per cycle.
- Reset mid-operation: all state returns to reset values at that edge; an in-flight gnt is cancelled (gnt=0 in the following cycle).

Decomposition:
- Package ticket_arb_pkg holds:
  - the FSM state enum (IDLE, GRANT, CLEAR);
  - the WIDTH default constant;
  - a function that returns the next round-robin index from a request vector and a pointer.
- One natural sub-module, rr_pick: combinational round-robin priority picker. Inputs: masked req vector and rr_ptr. Outputs: found, idx. It is reusable by other arbiters.
- Counter, FSM and output registers stay in ticket_arbiter.

Test Plan:
- Reset then idle: assert rst 2 cycles, req=0 -> all outputs 0, count=0; no gnt for 10 cycles.
- Single requester: req=4'b0010 held -> gnt=4'b0010, gnt_id=1, gnt_ticket=0 one cycle later. Requester drops req after gnt -> count=1, no second grant.
- Round-robin fairness: req=4'b1111 held constantly -> gnt order ids 0,1,2,3,0,... on consecutive cycles with tickets 0,1,2,3,4. No requester is granted twice before the others.
- Wrap: preload by granting 255 tickets, then one more request -> gnt_ticket=255, wrap=1, count=0 in that cycle. The next grant carries ticket 0.
- clr collision: count=17, req=4'b0100 and clr=1 in the same cycle -> no grant, count=0 next cycle; the following cycle gives gnt_id=2, gnt_ticket=0.
- en gating and mid-op reset: en=0 with req=4'b1001 -> no grants, count holds. Then set en=1 and pulse rst in the same cycle as the first gnt -> gnt cleared next cycle, count=0, rr_ptr=0.

Source files
------------

// File: rtl/ticket_arbiter_pkg.sv
// Shared types and helpers for the ticket arbiter: FSM state encoding,
// default ticket width and the round-robin index search.
`timescale 1ns/1ps
package ticket_arb_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int MAX_REQ   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      CLEAR = 2'd2
   } state_e;

   // First set bit of req_v at or after ptr, wrapping modulo n. Scanning offsets
   // downward lets the smallest offset win; returns ptr when nothing is set.
   function automatic int rr_next_idx(input logic [MAX_REQ-1:0] req_v,
                                      input int ptr,
                                      input int n);
      int idx;
      int cand;
      idx = ptr;
      for (int off = MAX_REQ - 1; off >= 0; off--) begin
         if (off < n) begin
            cand = ptr + off;
            if (cand >= n) cand = cand - n;
            if (req_v[cand]) idx = cand;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/ticket_arbiter_rr_pick.sv
// Combinational round-robin priority picker: lowest set request at or after
// the pointer wins, wrapping around the vector.
`timescale 1ns/1ps
module rr_pick
   import ticket_arb_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic          found_o,
   output logic [IW-1:0] idx_o
);

   assign found_o = |req_i;
   assign idx_o   = IW'(rr_next_idx(MAX_REQ'(req_i), int'(ptr_i), N));

endmodule

// File: rtl/ticket_arbiter.sv
// Round-robin arbiter handing out tickets from one shared wrapping counter;
// each grant is a registered one-cycle pulse carrying the pre-increment count.
`timescale 1ns/1ps
module ticket_arbiter
   import ticket_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int WIDTH   = WIDTH_DEF,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clr,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_id,
   output logic [WIDTH-1:0]   gnt_ticket,
   output logic               wrap,
   output logic [WIDTH-1:0]   count
);

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
   logic [WIDTH-1:0]   ticket_q, ticket_d;
   logic               wrap_q, wrap_d;
   logic [WIDTH-1:0]   count_q, count_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;

   logic [NUM_REQ-1:0] elig;
   logic               found;
   logic [ID_W-1:0]    pick_idx;

   // The requester granted this cycle may still hold req at the next edge.
   assign elig = req & ~gnt_q;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .req_i   (elig),
      .ptr_i   (ptr_q),
      .found_o (found),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = IDLE;
      if (clr)               state_d = CLEAR;
      else if (en && found)  state_d = GRANT;
   end

   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      gnt_d    = '0;
      gnt_id_d = gnt_id_q;
      ticket_d = ticket_q;
      wrap_d   = 1'b0;
      count_d  = count_q;
      ptr_d    = ptr_q;
      unique case (state_d)
         GRANT: begin
            gnt_d    = NUM_REQ'(1) << pick_idx;
            gnt_id_d = pick_idx;
            ticket_d = count_q;
            count_d  = count_q + WIDTH'(1);
            wrap_d   = &count_q;
            ptr_d    = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + ID_W'(1);
         end
         CLEAR:   count_d = '0;
         default: ;
      endcase
   end

   // NOTE: reset is synchronous and non-blocking assignments keep every
   // register sampling the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q    <= '0;
         gnt_id_q <= '0;
         ticket_q <= '0;
         wrap_q   <= 1'b0;
         count_q  <= '0;
         ptr_q    <= '0;
      end else begin
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         ticket_q <= ticket_d;
         wrap_q   <= wrap_d;
         count_q  <= count_d;
         ptr_q    <= ptr_d;
      end
   end

   assign gnt        = gnt_q;
   assign gnt_valid  = (state_q == GRANT);
   assign gnt_id     = gnt_id_q;
   assign gnt_ticket = ticket_q;
   assign wrap       = wrap_q;
   assign count      = count_q;

endmodule

// File: tb/tb_ticket_arbiter.sv
// Directed bench for ticket_arbiter: reset, single grants, stale-req masking,
// round-robin order, counter wrap, clr collision, en gating and mid-op reset.
`timescale 1ns/1ps
module tb_ticket_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;
   localparam int ID_W    = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic               clr;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic               gnt_valid;
   logic [ID_W-1:0]    gnt_id;
   logic [WIDTH-1:0]   gnt_ticket;
   logic               wrap;
   logic [WIDTH-1:0]   count;

   int n_chk  = 0;
   int n_fail = 0;

   ticket_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .clr        (clr),
      .req        (req),
      .gnt        (gnt),
      .gnt_valid  (gnt_valid),
      .gnt_id     (gnt_id),
      .gnt_ticket (gnt_ticket),
      .wrap       (wrap),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_grant(input string tag, input int id, input int ticket, input int cnt);
      check({tag, " valid"},  32'(gnt_valid),  32'd1);
      check({tag, " gnt"},    32'(gnt),        32'(1) << id);
      check({tag, " id"},     32'(gnt_id),     32'(id));
      check({tag, " ticket"}, 32'(gnt_ticket), 32'(ticket));
      check({tag, " count"},  32'(count),      32'(cnt));
   endtask

   task automatic check_idle(input string tag, input int cnt);
      check({tag, " valid"}, 32'(gnt_valid), 32'd0);
      check({tag, " gnt"},   32'(gnt),       32'd0);
      check({tag, " count"}, 32'(count),     32'(cnt));
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; en = 1'b0; clr = 1'b0; req = '0;

      // Reset, then idle
      step(); step();
      check("rst gnt",    32'(gnt),        32'd0);
      check("rst valid",  32'(gnt_valid),  32'd0);
      check("rst id",     32'(gnt_id),     32'd0);
      check("rst ticket", 32'(gnt_ticket), 32'd0);
      check("rst wrap",   32'(wrap),       32'd0);
      check("rst count",  32'(count),      32'd0);
      rst = 1'b0; en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle valid", 32'(gnt_valid), 32'd0);
      end

      // Single requester, drops req after seeing gnt
      req = 4'b0010;
      step(); check_grant("single", 1, 0, 1);
      req = 4'b0000;
      step(); check_idle("single drop", 1);

      // Stale req held one cycle past its grant must be masked
      req = 4'b0100;
      step(); check_grant("stale grant", 2, 1, 2);
      step(); check_idle("stale mask", 2);
      req = 4'b0000;
      step(); check_idle("stale drop", 2);

      // Fresh reset puts rr_ptr back to 0 for the fairness run
      rst = 1'b1;
      step(); check_idle("rst2", 0);
      rst = 1'b0;

      // Round-robin with all requesters active
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step(); check_grant("rr", i % 4, i, i + 1);
      end
      req = 4'b0000;
      step(); check_idle("rr drop", 5);

      // Run the counter up to 255, then the wrapping grant
      req = 4'b1111;
      for (int i = 0; i < 300 && count !== 8'd255; i++) step();
      check("preload count",  32'(count),      32'd255);
      check("preload ticket", 32'(gnt_ticket), 32'd254);
      step();
      check("wrap ticket", 32'(gnt_ticket), 32'd255);
      check("wrap pulse",  32'(wrap),       32'd1);
      check("wrap count",  32'(count),      32'd0);
      check("wrap valid",  32'(gnt_valid),  32'd1);
      step();
      check("post-wrap ticket", 32'(gnt_ticket), 32'd0);
      check("post-wrap pulse",  32'(wrap),       32'd0);
      check("post-wrap count",  32'(count),      32'd1);
      req = 4'b0000;
      step(); check_idle("wrap drop", 1);

      // clr collides with a pending request
      req = 4'b1111;
      for (int i = 0; i < 100 && count !== 8'd17; i++) step();
      check("pre-clr count", 32'(count), 32'd17);
      req = 4'b0100; clr = 1'b1;
      step(); check_idle("clr", 0);
      clr = 1'b0;
      step(); check_grant("after clr", 2, 0, 1);
      req = 4'b1000;
      step(); check_grant("id3", 3, 1, 2);

      // en low holds everything
      en = 1'b0; req = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         step(); check_idle("en low", 2);
      end
      en = 1'b1;
      step(); check_grant("en high", 0, 2, 3);

      // Reset in the same cycle as a visible grant
      rst = 1'b1;
      step();
      check_idle("midrst", 0);
      check("midrst id",     32'(gnt_id),     32'd0);
      check("midrst ticket", 32'(gnt_ticket), 32'd0);
      check("midrst wrap",   32'(wrap),       32'd0);
      rst = 1'b0;
      step(); check_grant("after midrst", 0, 0, 1);
      req = 4'b0000;
      step(); check_idle("final", 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
